alu_seq: RTL and testbench
==========================

# alu_seq

Sequential execute-stage ALU: consumes the operation code produced by ALU control and the two operand buses, and returns a registered result with a start/busy/done handshake. Logic and arithmetic ops complete in one cycle; shifts run iteratively, one bit per cycle, unless the barrel-shifter build option is compiled in. It sits in EX between the ID/EX register and the EX/MEM register, and its busy output feeds the hazard unit as a stall request.

## Interface
- ALU_CTR_BUS_WIDTH, `DEFAULT_ALU_CTR_BUS_WIDTH, width of the operation code (same value ALU control uses)
- DATA_BUS_WIDTH, 32, operand/result width
- SHAMT_BUS_WIDTH, 5, shift-amount width (log2 DATA_BUS_WIDTH)
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  request; accepted only when o_busy=0
- i_flush  in  1  synchronous abort of an in-progress shift
- i_alu_ctr  in  ALU_CTR_BUS_WIDTH  operation code (CODE_ALU_EX_*)
- i_data_a  in  DATA_BUS_WIDTH  operand A (rs); [4:0] = variable shift amount
- i_data_b  in  DATA_BUS_WIDTH  operand B (rt/immediate); operand being shifted
- i_shamt  in  SHAMT_BUS_WIDTH  fixed shift amount for SLL/SRL/SRA
- o_result  out  DATA_BUS_WIDTH  result, held until next accepted start
- o_zero  out  1  o_result == 0
- o_overflow  out  1  signed overflow of ADD/SUB
- o_busy  out  1  shift in progress; start ignored
- o_done  out  1  one-cycle pulse, result valid

## Operation
- States: IDLE, SHIFT. Reset -> IDLE; o_result=0, o_zero=1, o_overflow=0, o_busy=0, o_done=0, counter=0.
- Accept: i_start=1 and o_busy=0 (IDLE, including the cycle o_done is high). Operands, code, shift amount captured on the accepting edge; later input changes ignored.
- ADD/SUB: 32-bit two's-complement; o_overflow = signed overflow. ADDU/SUBU: same result, o_overflow=0. AND/OR/XOR/NOR bitwise. SLT: signed A<B -> 1 else 0. SC_B: result = B (link address pass-through). NOP or unknown code: result 0. o_overflow=0 for every op except ADD/SUB.
- Shifts: SLL/SRL/SRA use i_shamt; SLLV/SRLV/SRAV use i_data_a[4:0]. SRA/SRAV replicate B[31]. Count n taken modulo 32.
- Shift with n>0: load B and n, enter SHIFT; each edge shifts one bit, decrements counter; counter reaching 0 -> IDLE with o_done pulse. n=0 behaves as a one-cycle op (result = B).
- i_flush in SHIFT: -> IDLE next edge, no o_done, o_result/o_zero/o_overflow keep previous values. i_flush in IDLE: no effect, except flush+start same cycle: flush wins, start dropped.
- i_start while busy: ignored, no queuing.
- Async reset mid-shift: immediate return to reset values.

## Timing
- One-cycle ops: accepted at edge E0; o_result/flags valid and o_done=1 in the cycle after E0.
- Shift n>0: o_busy=1 after E0 through E(n-1); o_done=1 and result valid after En. Total latency n+1 edges (n=31 -> 32).
- Back-to-back: new start accepted in the o_done cycle; o_done may stay high on consecutive cycles for consecutive one-cycle ops.
- o_busy, o_done, o_result all registered; no combinational path from inputs to outputs.

## Configuration
- ALU_BARREL_SHIFTER_EN defined: shifts use a combinational barrel shifter, complete in one cycle like other ops; SHIFT state, counter never used; o_busy constant 0.
- Not defined: iterative shifter as above, o_busy per Timing. Results identical in both builds; only latency differs.

## Structure
- Shared header (alu.vh alongside alu_control.vh): CODE_ALU_EX_* operation codes, DEFAULT_ALU_CTR_BUS_WIDTH, state encodings; ALU control and this block include the same definitions.
- One sub-module: alu_shifter (load/step/count interface; barrel variant selected by the macro). Arithmetic/logic stays in alu_seq.

## Test plan
- ADD A=0x7FFFFFFF B=1 -> o_result=0x80000000, o_overflow=1, o_done one cycle after start; ADDU same -> o_overflow=0.
- SUB A=5 B=5 -> o_result=0, o_zero=1; SLT A=0xFFFFFFFF B=1 -> 1; NOR A=0 B=0 -> 0xFFFFFFFF.
- SRA B=0x80000000 i_shamt=4 -> 0xF8000000; busy 4 cycles, o_done after 5th edge (1 cycle with ALU_BARREL_SHIFTER_EN).
- SLLV A=0x25 B=1 -> count 5, result 0x20; shamt=0 -> result=B, done after 1 cycle; start pulses during busy ignored.
- SRL n=10 with i_flush after 3 busy cycles -> IDLE, no o_done, o_result unchanged; flush+start same cycle -> no accept.
- Async reset asserted mid-shift -> o_busy=0, o_result=0, o_zero=1 immediately; next start after release completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared ALU definitions: execute-stage operation codes, control bus width,
// FSM state and shift-kind encodings used by alu_seq and alu_shifter.
package alu_seq_pkg;

  localparam int DEFAULT_ALU_CTR_BUS_WIDTH = 5;

  localparam logic [4:0] CODE_ALU_EX_NOP  = 5'd0;
  localparam logic [4:0] CODE_ALU_EX_ADD  = 5'd1;
  localparam logic [4:0] CODE_ALU_EX_ADDU = 5'd2;
  localparam logic [4:0] CODE_ALU_EX_SUB  = 5'd3;
  localparam logic [4:0] CODE_ALU_EX_SUBU = 5'd4;
  localparam logic [4:0] CODE_ALU_EX_AND  = 5'd5;
  localparam logic [4:0] CODE_ALU_EX_OR   = 5'd6;
  localparam logic [4:0] CODE_ALU_EX_XOR  = 5'd7;
  localparam logic [4:0] CODE_ALU_EX_NOR  = 5'd8;
  localparam logic [4:0] CODE_ALU_EX_SLT  = 5'd9;
  localparam logic [4:0] CODE_ALU_EX_SLL  = 5'd10;
  localparam logic [4:0] CODE_ALU_EX_SRL  = 5'd11;
  localparam logic [4:0] CODE_ALU_EX_SRA  = 5'd12;
  localparam logic [4:0] CODE_ALU_EX_SLLV = 5'd13;
  localparam logic [4:0] CODE_ALU_EX_SRLV = 5'd14;
  localparam logic [4:0] CODE_ALU_EX_SRAV = 5'd15;
  localparam logic [4:0] CODE_ALU_EX_SC_B = 5'd16;

  typedef enum logic {ST_IDLE, ST_SHIFT} alu_state_e;

  typedef enum logic [1:0] {SHIFT_LL, SHIFT_RL, SHIFT_RA} shift_kind_e;

endpackage

// File: rtl/alu_shifter.sv
// Shifter for alu_seq: one bit per step with a down-counter by default, or a
// combinational barrel shifter when ALU_BARREL_SHIFTER_EN is defined.
module alu_shifter
  import alu_seq_pkg::*;
#(
  parameter int DATA_BUS_WIDTH  = 32,
  parameter int SHAMT_BUS_WIDTH = 5
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_load,
  input  logic                       i_step,
  input  logic                       i_clear,
  input  logic [DATA_BUS_WIDTH-1:0]  i_data,
  input  logic [SHAMT_BUS_WIDTH-1:0] i_amount,
  input  shift_kind_e                i_kind,
  output logic [DATA_BUS_WIDTH-1:0]  o_result,
  output logic                       o_last
);

`ifdef ALU_BARREL_SHIFTER_EN
  // o_result is the full shift of the live inputs; no state is kept.
  logic unused_sink;
  assign unused_sink = ^{i_clk, i_reset, i_load, i_step, i_clear};
  assign o_last = 1'b1;

  always_comb begin
    o_result = i_data;
    case (i_kind)
      SHIFT_LL: o_result = i_data << i_amount;
      SHIFT_RL: o_result = i_data >> i_amount;
      SHIFT_RA: o_result = $signed(i_data) >>> i_amount;
      default:  o_result = i_data;
    endcase
  end
`else
  logic [DATA_BUS_WIDTH-1:0]  value_reg;
  logic [DATA_BUS_WIDTH-1:0]  value_next;
  logic [SHAMT_BUS_WIDTH-1:0] count_reg;
  shift_kind_e                kind_reg;

  always_comb begin
    value_next = value_reg;
    case (kind_reg)
      SHIFT_LL: value_next = {value_reg[DATA_BUS_WIDTH-2:0], 1'b0};
      SHIFT_RL: value_next = {1'b0, value_reg[DATA_BUS_WIDTH-1:1]};
      SHIFT_RA: value_next = {value_reg[DATA_BUS_WIDTH-1], value_reg[DATA_BUS_WIDTH-1:1]};
      default:  value_next = value_reg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      value_reg <= '0;
      count_reg <= '0;
      kind_reg  <= SHIFT_LL;
    end else if (i_clear) begin
      count_reg <= '0;
    end else if (i_load) begin
      value_reg <= i_data;
      count_reg <= i_amount;
      kind_reg  <= i_kind;
    end else if (i_step && (count_reg != '0)) begin
      value_reg <= value_next;
      count_reg <= count_reg - 1'b1;
    end
  end

  // o_result is the value after the step taken on the coming edge.
  assign o_result = value_next;
  assign o_last   = (count_reg == SHAMT_BUS_WIDTH'(1));
`endif

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with start/busy/done handshake; shifts are iterative unless
// ALU_BARREL_SHIFTER_EN is defined, in which case every op takes one cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int ALU_CTR_BUS_WIDTH = DEFAULT_ALU_CTR_BUS_WIDTH,
  parameter int DATA_BUS_WIDTH    = 32,
  parameter int SHAMT_BUS_WIDTH   = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_flush,
  input  logic [ALU_CTR_BUS_WIDTH-1:0] i_alu_ctr,
  input  logic [DATA_BUS_WIDTH-1:0]    i_data_a,
  input  logic [DATA_BUS_WIDTH-1:0]    i_data_b,
  input  logic [SHAMT_BUS_WIDTH-1:0]   i_shamt,
  output logic [DATA_BUS_WIDTH-1:0]    o_result,
  output logic                         o_zero,
  output logic                         o_overflow,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int MSB = DATA_BUS_WIDTH - 1;

  alu_state_e                 state_reg, state_next;
  logic [DATA_BUS_WIDTH-1:0]  result_reg, result_next;
  logic                       ovf_reg, ovf_next;
  logic                       done_reg, done_next;

  logic [DATA_BUS_WIDTH-1:0]  sum, diff, op_result, shift_value, sh_result;
  logic                       op_ovf, is_shift, var_amount, shift_long, sh_last;
  logic                       accept, sh_load, sh_step, sh_clear;
  logic [SHAMT_BUS_WIDTH-1:0] amount;
  shift_kind_e                kind;

  assign sum    = i_data_a + i_data_b;
  assign diff   = i_data_a - i_data_b;
  assign amount = var_amount ? i_data_a[SHAMT_BUS_WIDTH-1:0] : i_shamt;
  assign accept = i_start && !i_flush && (state_reg == ST_IDLE);

  always_comb begin
    op_result  = '0;
    op_ovf     = 1'b0;
    is_shift   = 1'b0;
    var_amount = 1'b0;
    kind       = SHIFT_LL;
    case (i_alu_ctr)
      CODE_ALU_EX_ADD: begin
        op_result = sum;
        op_ovf    = (i_data_a[MSB] == i_data_b[MSB]) && (sum[MSB] != i_data_a[MSB]);
      end
      CODE_ALU_EX_ADDU: op_result = sum;
      CODE_ALU_EX_SUB: begin
        op_result = diff;
        op_ovf    = (i_data_a[MSB] != i_data_b[MSB]) && (diff[MSB] != i_data_a[MSB]);
      end
      CODE_ALU_EX_SUBU: op_result = diff;
      CODE_ALU_EX_AND:  op_result = i_data_a & i_data_b;
      CODE_ALU_EX_OR:   op_result = i_data_a | i_data_b;
      CODE_ALU_EX_XOR:  op_result = i_data_a ^ i_data_b;
      CODE_ALU_EX_NOR:  op_result = ~(i_data_a | i_data_b);
      CODE_ALU_EX_SLT:  op_result = {{(DATA_BUS_WIDTH-1){1'b0}}, $signed(i_data_a) < $signed(i_data_b)};
      CODE_ALU_EX_SC_B: op_result = i_data_b;
      CODE_ALU_EX_SLL:  begin is_shift = 1'b1; kind = SHIFT_LL; end
      CODE_ALU_EX_SRL:  begin is_shift = 1'b1; kind = SHIFT_RL; end
      CODE_ALU_EX_SRA:  begin is_shift = 1'b1; kind = SHIFT_RA; end
      CODE_ALU_EX_SLLV: begin is_shift = 1'b1; kind = SHIFT_LL; var_amount = 1'b1; end
      CODE_ALU_EX_SRLV: begin is_shift = 1'b1; kind = SHIFT_RL; var_amount = 1'b1; end
      CODE_ALU_EX_SRAV: begin is_shift = 1'b1; kind = SHIFT_RA; var_amount = 1'b1; end
      default: op_result = '0;
    endcase
    if (is_shift) op_result = shift_value;
  end

`ifdef ALU_BARREL_SHIFTER_EN
  logic unused_last;
  assign unused_last = sh_last;
  assign shift_value = sh_result;
  assign shift_long  = 1'b0;
  assign o_busy      = 1'b0;
`else
  // A zero-length shift is just a pass-through of B and finishes in one cycle.
  assign shift_value = i_data_b;
  assign shift_long  = (amount != '0);
  assign o_busy      = (state_reg == ST_SHIFT);
`endif

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    done_next   = 1'b0;
    sh_load     = 1'b0;
    sh_step     = 1'b0;
    sh_clear    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift && shift_long) begin
            sh_load    = 1'b1;
            state_next = ST_SHIFT;
          end else begin
            result_next = op_result;
            ovf_next    = op_ovf;
            done_next   = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (i_flush) begin
          sh_clear   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          sh_step = 1'b1;
          if (sh_last) begin
            result_next = sh_result;
            ovf_next    = 1'b0;
            done_next   = 1'b1;
            state_next  = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      done_reg   <= done_next;
    end
  end

  alu_shifter #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
    .SHAMT_BUS_WIDTH(SHAMT_BUS_WIDTH)
  ) u_shifter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (sh_load),
    .i_step  (sh_step),
    .i_clear (sh_clear),
    .i_data  (i_data_b),
    .i_amount(amount),
    .i_kind  (kind),
    .o_result(sh_result),
    .o_last  (sh_last)
  );

  assign o_result   = result_reg;
  assign o_zero     = (result_reg == '0);
  assign o_overflow = ovf_reg;
  assign o_done     = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with hand-computed results; latency expectations
// follow ALU_BARREL_SHIFTER_EN when it is defined.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [4:0]  alu_ctr;
  logic [31:0] data_a, data_b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero, overflow, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_start   (start),
    .i_flush   (flush),
    .i_alu_ctr (alu_ctr),
    .i_data_a  (data_a),
    .i_data_b  (data_b),
    .i_shamt   (shamt),
    .o_result  (result),
    .o_zero    (zero),
    .o_overflow(overflow),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    start   = 1'b1;
    alu_ctr = code;
    data_a  = a;
    data_b  = b;
    shamt   = sh;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ovf);
    drive(code, a, b, 5'd0);
    @(posedge clk); #1;
    start = 1'b0;
    $display("op %s a=%h b=%h result=%h ovf=%0b done=%0b", tag, a, b, result, overflow, done);
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".res"}, result, exp_res);
    check({tag, ".ovf"}, overflow, exp_ovf);
    check({tag, ".zero"}, zero, (exp_res == 32'd0));
  endtask

  task automatic run_shift(input string tag, input logic [4:0] code, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input int n,
                           input logic [31:0] exp_res, input bit pulse);
    int edges = 0;
    int busy_cycles = 0;
    int exp_edges, exp_busy;
`ifdef ALU_BARREL_SHIFTER_EN
    exp_edges = 1;
    exp_busy  = 0;
`else
    exp_edges = n + 1;
    exp_busy  = n;
`endif
    drive(code, a, b, sh);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) break;
      if (pulse && edges == 1) drive(CODE_ALU_EX_ADD, 32'd1, 32'd1, 5'd0);
    end
    start = 1'b0;
    $display("shift %s b=%h n=%0d result=%h edges=%0d", tag, b, n, result, edges);
    check({tag, ".lat"}, edges, exp_edges);
    check({tag, ".busy"}, busy_cycles, exp_busy);
    check({tag, ".res"}, result, exp_res);
    check({tag, ".ovf"}, overflow, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    alu_ctr = '0; data_a = '0; data_b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.res", result, 32'd0);
    check("rst.zero", zero, 1'b1);
    check("rst.ovf", overflow, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back one-cycle ops
    do_op("add_ovf", CODE_ALU_EX_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    do_op("addu", CODE_ALU_EX_ADDU, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    do_op("sub_eq", CODE_ALU_EX_SUB, 32'd5, 32'd5, 32'd0, 1'b0);
    do_op("sub_ovf", CODE_ALU_EX_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
    do_op("subu", CODE_ALU_EX_SUBU, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0);
    do_op("slt_t", CODE_ALU_EX_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    do_op("slt_f", CODE_ALU_EX_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    do_op("nor", CODE_ALU_EX_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    do_op("and", CODE_ALU_EX_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
    do_op("or", CODE_ALU_EX_OR, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0);
    do_op("xor", CODE_ALU_EX_XOR, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0);
    do_op("sc_b", CODE_ALU_EX_SC_B, 32'hDEAD, 32'h1234, 32'h1234, 1'b0);
    do_op("unk", 5'd31, 32'h5, 32'h6, 32'h0, 1'b0);
    do_op("add_ovf2", CODE_ALU_EX_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);

    // Shifts
    run_shift("sra4", CODE_ALU_EX_SRA, 32'h0, 32'h8000_0000, 5'd4, 4, 32'hF800_0000, 1'b1);
    run_shift("sllv5", CODE_ALU_EX_SLLV, 32'h25, 32'h1, 5'd0, 5, 32'h20, 1'b0);
    run_shift("srl0", CODE_ALU_EX_SRL, 32'h0, 32'hABCD, 5'd0, 0, 32'hABCD, 1'b0);
    run_shift("srav1", CODE_ALU_EX_SRAV, 32'h21, 32'h8000_0001, 5'd0, 1, 32'hC000_0000, 1'b0);
    run_shift("srl28", CODE_ALU_EX_SRL, 32'h0, 32'hF000_0000, 5'd28, 28, 32'h0000_000F, 1'b0);
    run_shift("sll31", CODE_ALU_EX_SLL, 32'h0, 32'h1, 5'd31, 31, 32'h8000_0000, 1'b0);

    do_op("pre_flush", CODE_ALU_EX_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
`ifndef ALU_BARREL_SHIFTER_EN
    // Flush after three busy cycles
    drive(CODE_ALU_EX_SRL, 32'h0, 32'hFFFF_0000, 5'd10);
    @(posedge clk); #1;
    start = 1'b0;
    check("flush.busy0", busy, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    check("flush.busy2", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("flush mid-shift result=%h busy=%0b done=%0b", result, busy, done);
    check("flush.busy", busy, 1'b0);
    check("flush.done", done, 1'b0);
    check("flush.res", result, 32'd5);
    done_seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done) done_seen++; end
    check("flush.nodone", done_seen, 0);
`endif
    // Flush and start together: start is dropped
    drive(CODE_ALU_EX_ADD, 32'd1, 32'd1, 5'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    $display("flush+start result=%h done=%0b", result, done);
    check("fs.done", done, 1'b0);
    check("fs.res", result, 32'd5);
    check("fs.busy", busy, 1'b0);

    // Asynchronous reset in the middle of a shift
    drive(CODE_ALU_EX_SRL, 32'h0, 32'hFFFF_0000, 5'd10);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("async reset result=%h busy=%0b zero=%0b", result, busy, zero);
    check("arst.busy", busy, 1'b0);
    check("arst.res", result, 32'd0);
    check("arst.zero", zero, 1'b1);
    check("arst.done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst", CODE_ALU_EX_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
    run_shift("post_srl10", CODE_ALU_EX_SRL, 32'h0, 32'hFFFF_0000, 5'd10, 10, 32'h003F_FFC0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
